mmio_rtc: RTL and testbench

//   Memory-mapped real-time-clock/button responder on the core's data bus (same we/a/wd/rd

---
 rtl/mmio_rtc_if.sv | 13 +
 rtl/mmio_rtc.sv | 163 ++++++++++++++++
 tb/tb_mmio_rtc.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_rtc_if.sv
// Data-bus handshake shared with dmem: the core drives the store strobe,
// address and store data, and the responder returns load data and its
// address-decode hit.
interface mmio_rtc_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        hit;

    modport master (output we, a, wd, input rd, hit);
    modport slave  (input we, a, wd, output rd, hit);
endinterface

// File: rtl/mmio_rtc.sv
// mmio_rtc: memory-mapped seconds-of-day clock with prescaler, plus a
// debounced btn0 level and a sticky press flag, answering core loads/stores.
// Optional feature: define MMIO_RTC_IRQ_EN to add the irq output and the
// CTRL.ie bit; without it CTRL[2] reads 0 and writes to it are ignored.
//
// Register map (a[3:2]):
//   0x0 CTRL     [0] run, [1] clear (self-clearing, reads 0), [2] ie
//   0x4 PRESCALE cycles-per-second minus 1
//   0x8 SECONDS  [16:0] seconds of day
//   0xC STATUS   [0] btn level, [1] press sticky (W1C), [2] tick sticky (W1C)
module mmio_rtc #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter int unsigned CLK_HZ          = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned DAY_SECONDS     = 86400
) (
    input  logic       clk,
    input  logic       reset,
    mmio_rtc_if.slave  bus,
    input  logic       btn
`ifdef MMIO_RTC_IRQ_EN
    ,
    output logic       irq
`endif
);

    localparam int unsigned DCNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DEB_LOAD   = DCNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0]       PRESC_RST  = 32'(CLK_HZ - 1);
    localparam logic [16:0]       DAY_LAST   = 17'(DAY_SECONDS - 1);

    logic        run;
    logic [31:0] prescale;
    logic [31:0] pcnt;          // cycles remaining until the next tick
    logic [16:0] seconds;
    logic        tickSticky;
    logic        pressSticky;
    logic        syncA;
    logic        syncB;
    logic        level;
    logic [DCNT_W-1:0] dcnt;    // mismatch cycles remaining before level follows
    logic        tick;
    logic        pressSet;
    logic        wrEn;
    logic        wrCtrl;
    logic        wrPrescale;
    logic        wrSeconds;
    logic        wrStatus;
    logic        doClear;
    logic        ieBit;
    logic [31:0] rdata;
    logic        unusedBits;

    assign unusedBits = ^bus.a[1:0];

    assign bus.hit    = (bus.a[31:4] == BASE_ADDR[31:4]);
    assign wrEn       = bus.we & bus.hit;
    assign wrCtrl     = wrEn & (bus.a[3:2] == 2'd0);
    assign wrPrescale = wrEn & (bus.a[3:2] == 2'd1);
    assign wrSeconds  = wrEn & (bus.a[3:2] == 2'd2);
    assign wrStatus   = wrEn & (bus.a[3:2] == 2'd3);
    assign doClear    = wrCtrl & bus.wd[1];

    // Down-counter reaching zero marks the last cycle of a second.
    assign tick     = run & (pcnt == '0);
    // Debounced rising edge: level is about to go 0->1 this cycle.
    assign pressSet = syncB & ~level & (dcnt == '0);

`ifdef MMIO_RTC_IRQ_EN
    logic ie;

    // Interrupt-enable bit lives in CTRL[2].
    always_ff @(posedge clk) begin
        if (reset)       ie <= 1'b0;
        else if (wrCtrl) ie <= bus.wd[2];
    end

    // Registered irq: follows the sticky flags one cycle later.
    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= ie & (pressSticky | tickSticky);
    end

    assign ieBit = ie;
`else
    assign ieBit = 1'b0;
`endif

    // CTRL run bit and the PRESCALE register.
    always_ff @(posedge clk) begin
        if (reset) begin
            run      <= 1'b0;
            prescale <= PRESC_RST;
        end else begin
            if (wrCtrl)     run      <= bus.wd[0];
            if (wrPrescale) prescale <= bus.wd;
        end
    end

    // Prescaler: reload on clear, on a PRESCALE write, or at the end of each period.
    always_ff @(posedge clk) begin
        if (reset)           pcnt <= PRESC_RST;
        else if (doClear)    pcnt <= prescale;
        else if (wrPrescale) pcnt <= bus.wd;
        else if (run)        pcnt <= (pcnt == '0) ? prescale : pcnt - 32'd1;
    end

    // Seconds of day: clear beats a software write, which beats the tick increment.
    always_ff @(posedge clk) begin
        if (reset)          seconds <= '0;
        else if (doClear)   seconds <= '0;
        else if (wrSeconds) seconds <= bus.wd[16:0];
        else if (tick)      seconds <= (seconds >= DAY_LAST) ? 17'd0 : seconds + 17'd1;
    end

    // Sticky flags: a new event in the same cycle as a W1C keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            tickSticky  <= 1'b0;
            pressSticky <= 1'b0;
        end else begin
            tickSticky  <= tick     | (tickSticky  & ~(wrStatus & bus.wd[2]));
            pressSticky <= pressSet | (pressSticky & ~(wrStatus & bus.wd[1]));
        end
    end

    // Button synchroniser and debouncer: level follows only after a stable run.
    always_ff @(posedge clk) begin
        if (reset) begin
            syncA <= 1'b0;
            syncB <= 1'b0;
            level <= 1'b0;
            dcnt  <= DEB_LOAD;
        end else begin
            syncA <= btn;
            syncB <= syncA;
            if (syncB == level) begin
                dcnt <= DEB_LOAD;
            end else if (dcnt == '0) begin
                level <= syncB;
                dcnt  <= DEB_LOAD;
            end else begin
                dcnt <= dcnt - 1'b1;
            end
        end
    end

    // Load data mux; zero when the address misses this block.
    always_comb begin
        rdata = '0;
        if (bus.hit) begin
            case (bus.a[3:2])
                2'd0:    rdata = {29'd0, ieBit, 1'b0, run};
                2'd1:    rdata = prescale;
                2'd2:    rdata = {15'd0, seconds};
                default: rdata = {29'd0, tickSticky, pressSticky, level};
            endcase
        end
    end

    assign bus.rd = rdata;

endmodule

// File: tb/tb_mmio_rtc.sv
// Directed bench for mmio_rtc with CLK_HZ=10, DEBOUNCE_CYCLES=4.
module tb_mmio_rtc;

    logic clk;
    logic reset;
    logic btn;
`ifdef MMIO_RTC_IRQ_EN
    logic irq;
    localparam logic [31:0] IE_RB = 32'h4;
`else
    localparam logic [31:0] IE_RB = 32'h0;
`endif

    int nCompared;
    int nMismatched;

    mmio_rtc_if bus();

    mmio_rtc #(
        .BASE_ADDR(32'h0000_1000),
        .CLK_HZ(10),
        .DEBOUNCE_CYCLES(4),
        .DAY_SECONDS(86400)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .btn(btn)
`ifdef MMIO_RTC_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        doWrite;
        logic [31:0] wAddr;
        logic [31:0] wData;
        logic [31:0] rAddr;
        logic [31:0] expRd;
        logic        expHit;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.we = 1'b1;
        bus.a  = addr;
        bus.wd = data;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic load(input logic [31:0] addr, output logic [31:0] d, output logic h);
        @(negedge clk);
        bus.we = 1'b0;
        bus.a  = addr;
        #1;
        d = bus.rd;
        h = bus.hit;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset  = 1'b1;
        bus.we = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        h;

        nCompared   = 0;
        nMismatched = 0;
        reset  = 1'b1;
        btn    = 1'b0;
        bus.we = 1'b0;
        bus.a  = '0;
        bus.wd = '0;

        vecs[0]  = '{"rst_ctrl",      1'b0, 32'h0,     32'h0,        32'h1000, 32'h0,     1'b1};
        vecs[1]  = '{"rst_prescale",  1'b0, 32'h0,     32'h0,        32'h1004, 32'h9,     1'b1};
        vecs[2]  = '{"rst_seconds",   1'b0, 32'h0,     32'h0,        32'h1008, 32'h0,     1'b1};
        vecs[3]  = '{"rst_status",    1'b0, 32'h0,     32'h0,        32'h100C, 32'h0,     1'b1};
        vecs[4]  = '{"miss_rd",       1'b0, 32'h0,     32'h0,        32'h2000, 32'h0,     1'b0};
        vecs[5]  = '{"prescale_wr",   1'b1, 32'h1004,  32'h1234,     32'h1004, 32'h1234,  1'b1};
        vecs[6]  = '{"miss_wr",       1'b1, 32'h2004,  32'hDEAD,     32'h1004, 32'h1234,  1'b1};
        vecs[7]  = '{"seconds_mask",  1'b1, 32'h1008,  32'hFFFF_FFFF, 32'h1008, 32'h1FFFF, 1'b1};
        vecs[8]  = '{"byte_offset",   1'b1, 32'h100A,  32'h7,        32'h1008, 32'h7,     1'b1};
        vecs[9]  = '{"ctrl_clear_rb", 1'b1, 32'h1000,  32'h6,        32'h1000, IE_RB,     1'b1};
        vecs[10] = '{"clear_seconds", 1'b0, 32'h0,     32'h0,        32'h1008, 32'h0,     1'b1};
        vecs[11] = '{"ctrl_zero",     1'b1, 32'h1000,  32'h0,        32'h1003, 32'h0,     1'b1};
        vecs[12] = '{"w1c_idle",      1'b1, 32'h100C,  32'h6,        32'h100F, 32'h0,     1'b1};
        vecs[13] = '{"prescale_9",    1'b1, 32'h1004,  32'h9,        32'h1004, 32'h9,     1'b1};
        vecs[14] = '{"miss_near",     1'b1, 32'h1FFC,  32'h55,       32'h0FFC, 32'h0,     1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Table: reset values, register write/readback, decode.
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].doWrite) store(vecs[i].wAddr, vecs[i].wData);
            load(vecs[i].rAddr, d, h);
            check({vecs[i].name, "_rd"}, d, vecs[i].expRd);
            check({vecs[i].name, "_hit"}, {31'd0, h}, {31'd0, vecs[i].expHit});
        end

        // Three seconds of running.
        doReset();
        store(32'h1000, 32'h1);
        repeat (30) @(posedge clk);
        load(32'h1008, d, h);
        check("run30_seconds", d, 32'd3);
        check("run30_hit", {31'd0, h}, 32'd1);
        load(32'h100C, d, h);
        check("run30_status", d, 32'h4);

        // Day wrap.
        store(32'h1000, 32'h0);
        store(32'h100C, 32'h4);
        store(32'h1008, 32'd86399);
        store(32'h1004, 32'h9);
        store(32'h1000, 32'h1);
        repeat (9) @(posedge clk);
        load(32'h1008, d, h);
        check("wrap_before", d, 32'd86399);
        load(32'h1008, d, h);
        check("wrap_after", d, 32'd0);
        load(32'h100C, d, h);
        check("wrap_tick_sticky", d, 32'h4);
        store(32'h1000, 32'h0);
        store(32'h100C, 32'h4);

        // Debounce: short glitch ignored, long press latched, W1C of press.
        @(negedge clk);
        btn = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        btn = 1'b0;
        repeat (10) @(posedge clk);
        load(32'h100C, d, h);
        check("glitch_status", d, 32'h0);
        @(negedge clk);
        btn = 1'b1;
        repeat (10) @(posedge clk);
        load(32'h100C, d, h);
        check("press_status", d, 32'h3);
        store(32'h100C, 32'h2);
        load(32'h100C, d, h);
        check("press_w1c", d, 32'h1);
        @(negedge clk);
        btn = 1'b0;
        repeat (10) @(posedge clk);
        load(32'h100C, d, h);
        check("release_status", d, 32'h0);

        // SECONDS write on the tick edge, then clear on the tick edge.
        store(32'h1004, 32'h9);
        store(32'h1008, 32'h0);
        store(32'h100C, 32'h4);
        store(32'h1000, 32'h1);
        repeat (9) @(posedge clk);
        store(32'h1008, 32'd5);
        load(32'h1008, d, h);
        check("tick_vs_write", d, 32'd5);
        repeat (9) @(posedge clk);
        store(32'h1000, 32'h3);
        load(32'h1008, d, h);
        check("tick_vs_clear", d, 32'd0);
        repeat (9) @(posedge clk);
        load(32'h1008, d, h);
        check("clear_pcnt_hold", d, 32'd0);
        load(32'h1008, d, h);
        check("clear_pcnt_tick", d, 32'd1);
        load(32'h1000, d, h);
        check("ctrl_after_clear", d, 32'h1);

        // PRESCALE=0: one second per cycle.
        store(32'h1004, 32'h0);
        load(32'h1008, s0, h);
        load(32'h1008, s1, h);
        load(32'h1008, s2, h);
        check("fast_step1", s1 - s0, 32'd1);
        check("fast_step2", s2 - s1, 32'd1);
        load(32'h2000, d, h);
        check("fast_miss_rd", d, 32'h0);
        check("fast_miss_hit", {31'd0, h}, 32'd0);
        store(32'h1000, 32'h0);

`ifdef MMIO_RTC_IRQ_EN
        // Interrupt follows the tick sticky and drops after W1C.
        doReset();
        store(32'h1000, 32'h5);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("irq_tick_edge", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check("irq_asserted", {31'd0, irq}, 32'd1);
        store(32'h100C, 32'h4);
        @(negedge clk);
        check("irq_w1c_edge", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        store(32'h1000, 32'h0);
`endif

        // Reset in the middle of counting and debouncing.
        store(32'h1004, 32'h3);
        store(32'h1000, 32'h1);
        @(negedge clk);
        btn = 1'b1;
        repeat (3) @(posedge clk);
        doReset();
        btn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load(vecs[i].rAddr, d, h);
            check({"midrst_", vecs[i].name}, d, vecs[i].expRd);
        end
        repeat (8) @(posedge clk);
        load(32'h100C, d, h);
        check("midrst_no_press", d, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
